// File: rtl/control_surface_scanner.sv
// ---------------------------------------------------------------------------
// control_surface_scanner
//
// Front-end for the synth's physical controls. Quadrature encoders are
// synchronised and decoded into saturating dial values. Active-low switches
// are synchronised, sampled on a slow tick and debounced. Every change to a
// dial value or switch state marks its channel pending. A round-robin arbiter
// then presents one change event at a time on a valid/ready port.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   quadA/quadB   in   raw encoder phases, one bit per dial (asynchronous)
//   switches_n    in   raw switches, active-low (asynchronous)
//   dial_values   out  dial d at [d*VALUE_BITS +: VALUE_BITS]
//   switch_state  out  debounced switch state, 1 = pressed
//   evt_valid     out  an event is presented
//   evt_ready     in   consumer accepts the presented event
//   evt_index     out  channel: dials 0..NUM_DIALS-1, then switches
//   evt_value     out  dial value, or the switch state in bit 0
//
// Handshake: an event transfers on any cycle where evt_valid && evt_ready.
// While evt_valid is high and evt_ready is low, evt_index and evt_value hold.
// evt_valid drops only after a transfer. The arbiter may load the next event
// in the same cycle as a transfer.
// ---------------------------------------------------------------------------
module control_surface_scanner #(
    parameter int NUM_DIALS    = 5,
    parameter int NUM_SWITCHES = 8,
    parameter int VALUE_BITS   = 7,
    parameter int DIAL_INIT    = 64,
    parameter int TICK_CYCLES  = 4000,
    parameter int IDX_BITS     = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_DIALS-1:0]            quadA,
    input  logic [NUM_DIALS-1:0]            quadB,
    input  logic [NUM_SWITCHES-1:0]         switches_n,
    output logic [NUM_DIALS*VALUE_BITS-1:0] dial_values,
    output logic [NUM_SWITCHES-1:0]         switch_state,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [IDX_BITS-1:0]             evt_index,
    output logic [VALUE_BITS-1:0]           evt_value
);

    localparam int NUM_CH = NUM_DIALS + NUM_SWITCHES;
    localparam int TW     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [VALUE_BITS-1:0] VMAX  = '1;
    localparam logic [VALUE_BITS-1:0] VINIT = VALUE_BITS'(DIAL_INIT);

    // Position of an {A,B} code along the forward sequence 00->10->11->01.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_pos = 2'd0;
            2'b10:   gray_pos = 2'd1;
            2'b11:   gray_pos = 2'd2;
            default: gray_pos = 2'd3;
        endcase
    endfunction

    // 1 = forward step, 3 = reverse step, 2 = both bits flipped, 0 = idle.
    function automatic logic [1:0] step_of(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        step_of = gray_pos(cur_ab) - gray_pos(prev_ab);
    endfunction

    // ---------------- input synchronisers ----------------
    logic [NUM_DIALS-1:0]    r_qa_s1, r_qa_s2, r_qb_s1, r_qb_s2;
    logic [NUM_SWITCHES-1:0] r_sw_s1, r_sw_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_qa_s1 <= '0;
            r_qa_s2 <= '0;
            r_qb_s1 <= '0;
            r_qb_s2 <= '0;
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_qa_s1 <= quadA;
            r_qa_s2 <= r_qa_s1;
            r_qb_s1 <= quadB;
            r_qb_s2 <= r_qb_s1;
            r_sw_s1 <= switches_n;
            r_sw_s2 <= r_sw_s1;
        end
    end

    // ---------------- quadrature decode ----------------
    logic [1:0]            r_ab_ref [NUM_DIALS];
    logic [1:0]            r_phase  [NUM_DIALS];
    logic [VALUE_BITS-1:0] r_dial   [NUM_DIALS];
    logic [1:0]            w_phase_nxt [NUM_DIALS];
    logic [VALUE_BITS-1:0] w_dial_nxt  [NUM_DIALS];
    logic [NUM_DIALS-1:0]  w_dial_chg;

    // The value moves only when the phase counter wraps, so one detent (four
    // edges) gives one step. A step clipped at either end is not a change.
    always_comb begin
        w_dial_chg = '0;
        for (int d = 0; d < NUM_DIALS; d++) begin
            w_phase_nxt[d] = r_phase[d];
            w_dial_nxt[d]  = r_dial[d];
            case (step_of(r_ab_ref[d], {r_qa_s2[d], r_qb_s2[d]}))
                2'd1: begin
                    w_phase_nxt[d] = r_phase[d] + 2'd1;
                    if (r_phase[d] == 2'd3 && r_dial[d] != VMAX) begin
                        w_dial_nxt[d] = r_dial[d] + 1'b1;
                        w_dial_chg[d] = 1'b1;
                    end
                end
                2'd3: begin
                    w_phase_nxt[d] = r_phase[d] - 2'd1;
                    if (r_phase[d] == 2'd0 && r_dial[d] != '0) begin
                        w_dial_nxt[d] = r_dial[d] - 1'b1;
                        w_dial_chg[d] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The reference always follows the synced code, so after an illegal
    // jump the next edge is decoded from the new code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < NUM_DIALS; d++) begin
                r_ab_ref[d] <= 2'b00;
                r_phase[d]  <= 2'd0;
                r_dial[d]   <= VINIT;
            end
        end else begin
            for (int d = 0; d < NUM_DIALS; d++) begin
                r_ab_ref[d] <= {r_qa_s2[d], r_qb_s2[d]};
                r_phase[d]  <= w_phase_nxt[d];
                r_dial[d]   <= w_dial_nxt[d];
            end
        end
    end

    // ---------------- switch debounce ----------------
    logic [TW-1:0]           r_tick_cnt;
    logic                    w_tick;
    logic [3:0]              r_hist [NUM_SWITCHES];
    logic [NUM_SWITCHES-1:0] r_sw_state, w_sw_nxt, w_sw_chg;

    assign w_tick = (r_tick_cnt == TW'(TICK_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            for (int i = 0; i < NUM_SWITCHES; i++) begin
                r_hist[i] <= 4'h0;
            end
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                for (int i = 0; i < NUM_SWITCHES; i++) begin
                    r_hist[i] <= {r_hist[i][2:0], ~r_sw_s2[i]};
                end
            end
        end
    end

    always_comb begin
        w_sw_nxt = r_sw_state;
        w_sw_chg = '0;
        for (int i = 0; i < NUM_SWITCHES; i++) begin
            if (r_hist[i] == 4'hF && !r_sw_state[i]) begin
                w_sw_nxt[i] = 1'b1;
                w_sw_chg[i] = 1'b1;
            end else if (r_hist[i] == 4'h0 && r_sw_state[i]) begin
                w_sw_nxt[i] = 1'b0;
                w_sw_chg[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_state <= '0;
        end else begin
            r_sw_state <= w_sw_nxt;
        end
    end

    // ---------------- change tracking and arbitration ----------------
    logic [NUM_CH-1:0]     r_chg;       // registered alongside the value update
    logic [NUM_CH-1:0]     r_pending;
    logic [NUM_CH-1:0]     w_clr, w_pend_eff;
    logic [VALUE_BITS-1:0] w_ch_val [NUM_CH];
    logic                  r_evt_valid;
    logic [IDX_BITS-1:0]   r_evt_idx, r_last;
    logic [VALUE_BITS-1:0] r_evt_val;
    logic                  w_hs, w_load;
    logic                  w_found_hi, w_found_lo, w_any;
    logic [IDX_BITS-1:0]   w_sel_hi, w_sel_lo, w_sel;
    logic [VALUE_BITS-1:0] w_sel_val;

    assign w_hs   = r_evt_valid & evt_ready;
    assign w_load = ~r_evt_valid | w_hs;

    always_comb begin
        for (int c = 0; c < NUM_DIALS; c++) begin
            w_ch_val[c] = r_dial[c];
        end
        for (int s = 0; s < NUM_SWITCHES; s++) begin
            w_ch_val[NUM_DIALS + s] = VALUE_BITS'(r_sw_state[s]);
        end
    end

    // A transfer retires the granted channel. A change arriving in the same
    // cycle is OR-ed back in below, so the new change still produces an event.
    always_comb begin
        w_clr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_clr[c] = w_hs && (r_evt_idx == IDX_BITS'(c));
        end
    end

    assign w_pend_eff = r_pending & ~w_clr;

    // Round-robin: lowest pending index above the last grant, else the lowest
    // pending index overall. Scanning downwards lets the lowest index win.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_sel_hi   = '0;
        w_sel_lo   = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_pend_eff[c]) begin
                if (IDX_BITS'(c) > r_last) begin
                    w_found_hi = 1'b1;
                    w_sel_hi   = IDX_BITS'(c);
                end else begin
                    w_found_lo = 1'b1;
                    w_sel_lo   = IDX_BITS'(c);
                end
            end
        end
        w_any = w_found_hi | w_found_lo;
        w_sel = w_found_hi ? w_sel_hi : w_sel_lo;
    end

    always_comb begin
        w_sel_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel == IDX_BITS'(c)) begin
                w_sel_val = w_ch_val[c];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chg     <= '0;
            r_pending <= '0;
        end else begin
            r_chg     <= {w_sw_chg, w_dial_chg};
            r_pending <= w_pend_eff | r_chg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evt_valid <= 1'b0;
            r_evt_idx   <= '0;
            r_evt_val   <= '0;
            r_last      <= IDX_BITS'(NUM_CH - 1);
        end else if (w_load) begin
            if (w_any) begin
                r_evt_valid <= 1'b1;
                r_evt_idx   <= w_sel;
                r_evt_val   <= w_sel_val;
                r_last      <= w_sel;
            end else begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    // ---------------- outputs ----------------
    for (genvar g = 0; g < NUM_DIALS; g++) begin : g_dial_out
        assign dial_values[g*VALUE_BITS +: VALUE_BITS] = r_dial[g];
    end

    assign switch_state = r_sw_state;
    assign evt_valid    = r_evt_valid;
    assign evt_index    = r_evt_idx;
    assign evt_value    = r_evt_val;

endmodule

// File: tb/tb_control_surface_scanner.sv
// Directed bench for control_surface_scanner with a short debounce tick.
module tb_control_surface_scanner;

  localparam int ND = 5;
  localparam int NS = 8;
  localparam int VB = 7;
  localparam int IB = 4;
  localparam int TC = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [ND-1:0]     quadA, quadB;
  logic [NS-1:0]     switches_n;
  logic [ND*VB-1:0]  dial_values;
  logic [NS-1:0]     switch_state;
  logic              evt_valid;
  logic              evt_ready;
  logic [IB-1:0]     evt_index;
  logic [VB-1:0]     evt_value;

  control_surface_scanner #(
    .NUM_DIALS(ND), .NUM_SWITCHES(NS), .VALUE_BITS(VB),
    .DIAL_INIT(64), .TICK_CYCLES(TC), .IDX_BITS(IB)
  ) dut (
    .clk(clk), .reset(reset), .quadA(quadA), .quadB(quadB),
    .switches_n(switches_n), .dial_values(dial_values),
    .switch_state(switch_state), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_index(evt_index), .evt_value(evt_value)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int ev_count = 0;
  int ev_idx = 0;
  int ev_val = 0;
  int base = 0;
  logic [ND*VB-1:0] init_vec;

  // Records every transfer, sampled on the falling edge.
  always @(negedge clk) begin
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      ev_count = ev_count + 1;
      ev_idx   = int'(evt_index);
      ev_val   = int'(evt_value);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [VB-1:0] dial_of(input int d);
    return dial_values[d*VB +: VB];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic edge_m(input logic [ND-1:0] mask, input logic a, input logic b);
    for (int d = 0; d < ND; d++) begin
      if (mask[d]) begin
        quadA[d] = a;
        quadB[d] = b;
      end
    end
    cyc(4);
  endtask

  task automatic cw_m(input logic [ND-1:0] mask);
    edge_m(mask, 1'b1, 1'b0);
    edge_m(mask, 1'b1, 1'b1);
    edge_m(mask, 1'b0, 1'b1);
    edge_m(mask, 1'b0, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int d = 0; d < ND; d++) init_vec[d*VB +: VB] = 7'd64;
    reset = 1'b1;
    quadA = '0;
    quadB = '0;
    switches_n = '1;
    evt_ready = 1'b0;
    cyc(3);

    check("rst_dials", dial_values, init_vec);
    check("rst_sw", switch_state, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_index", evt_index, 0);
    check("rst_value", evt_value, 0);

    reset = 1'b0;
    evt_ready = 1'b1;
    cyc(2);

    // 1: one detent on dial 2
    base = ev_count;
    cw_m(5'b00100);
    cyc(10);
    check("t1_dial2", dial_of(2), 65);
    check("t1_dial0", dial_of(0), 64);
    check("t1_count", ev_count - base, 1);
    check("t1_idx", ev_idx, 2);
    check("t1_val", ev_val, 65);

    // 2: dial 0 up to saturation, then beyond
    base = ev_count;
    repeat (63) cw_m(5'b00001);
    cyc(10);
    check("t2_dial0_max", dial_of(0), 127);
    check("t2_count", ev_count - base, 63);
    check("t2_idx", ev_idx, 0);
    check("t2_val", ev_val, 127);
    base = ev_count;
    repeat (8) cw_m(5'b00001);
    cyc(10);
    check("t2_dial0_sat", dial_of(0), 127);
    check("t2_no_evt", ev_count - base, 0);

    // 3: switch 3 bouncing, then held pressed, then released
    base = ev_count;
    switches_n[3] = 1'b0; cyc(TC);
    switches_n[3] = 1'b1; cyc(TC);
    switches_n[3] = 1'b0; cyc(TC);
    switches_n[3] = 1'b1; cyc(TC);
    check("t3_bounce", switch_state[3], 0);
    switches_n[3] = 1'b0;
    cyc(2 * TC);
    check("t3_early", switch_state[3], 0);
    check("t3_early_evt", ev_count - base, 0);
    cyc(5 * TC);
    check("t3_pressed", switch_state, 8'h08);
    check("t3_count", ev_count - base, 1);
    check("t3_idx", ev_idx, 8);
    check("t3_val", ev_val, 1);
    base = ev_count;
    switches_n[3] = 1'b1;
    cyc(60);
    check("t3_released", switch_state[3], 0);
    check("t3_rel_count", ev_count - base, 1);
    check("t3_rel_idx", ev_idx, 8);
    check("t3_rel_val", ev_val, 0);

    // 4: back-pressure with dials 1 and 4 changing together
    evt_ready = 1'b0;
    base = ev_count;
    cw_m(5'b10010);
    cyc(2);
    check("t4_valid", evt_valid, 1);
    check("t4_idx", evt_index, 1);
    check("t4_val", evt_value, 65);
    cyc(3);
    check("t4_hold_idx", evt_index, 1);
    check("t4_hold_val", evt_value, 65);
    check("t4_dial4", dial_of(4), 65);
    evt_ready = 1'b1;
    cyc(1);
    check("t4_next_valid", evt_valid, 1);
    check("t4_next_idx", evt_index, 4);
    check("t4_next_val", evt_value, 65);
    cyc(1);
    check("t4_drained", evt_valid, 0);
    check("t4_count", ev_count - base, 2);

    // 5: illegal 00->11 on dial 0, then a reverse edge from 11
    base = ev_count;
    edge_m(5'b00001, 1'b1, 1'b1);
    cyc(6);
    check("t5_illegal_val", dial_of(0), 127);
    check("t5_illegal_evt", ev_count - base, 0);
    edge_m(5'b00001, 1'b1, 1'b0);
    cyc(6);
    check("t5_dec_val", dial_of(0), 126);
    check("t5_dec_count", ev_count - base, 1);
    check("t5_dec_evt", ev_val, 126);
    edge_m(5'b00001, 1'b0, 1'b0);
    cyc(6);
    check("t5_mid_detent", dial_of(0), 126);

    // 6: asynchronous reset while an event is held
    evt_ready = 1'b0;
    cw_m(5'b01000);
    cyc(6);
    check("t6_held_valid", evt_valid, 1);
    check("t6_held_idx", evt_index, 3);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", evt_valid, 0);
    check("t6_async_dials", dial_values, init_vec);
    cyc(2);
    evt_ready = 1'b1;
    base = ev_count;
    reset = 1'b0;
    cyc(20);
    check("t6_post_valid", evt_valid, 0);
    check("t6_post_evt", ev_count - base, 0);
    check("t6_post_dials", dial_values, init_vec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
